irq_pending_latch: RTL and testbench

- Upstream stage for the 8-input priority encoder: captures eight asynchronous interrupt request lines and holds them as pending until software acknowledges them.
- Presents a masked, stable pending vector `ip[7:0]` that drives the encoder's `ip` input directly.
- Per line: synchronisation, rising-edge or level capture, sticky pending, indexed acknowledge, and a sticky overflow flag for lost edges.

---
 rtl/irq_pending_latch.sv | 94 +++++++++
 tb/tb_irq_pending_latch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// irq_pending_latch
// Captures eight asynchronous interrupt request lines, holds them as pending
// until acknowledged, and presents a masked pending vector to the downstream
// priority encoder. Each line is either rising-edge or level sensitive,
// selected at elaboration time by LEVEL_MASK. Edge lines also record a sticky
// overflow bit when a new edge arrives while the line is still pending.
module irq_pending_latch #(
  parameter int         SYNC_STAGES = 2,      // 2..4 synchroniser flops per line
  parameter logic [7:0] LEVEL_MASK  = 8'h00   // 1 = level-sensitive line
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       ack,
  input  logic [2:0] ack_idx,
  input  logic       clr_all,
  output logic [7:0] ip,
  output logic       any_pending,
  output logic [7:0] overflow
);

  // Synchroniser chain: stage 0 samples irq_in, the last stage is the
  // metastability-filtered view used by all capture logic.
  logic [SYNC_STAGES-1:0][7:0] r_sync;
  logic [7:0]                  r_prev;
  logic [7:0]                  r_pending;
  logic [7:0]                  r_overflow;

  logic [7:0] w_sync;
  logic [7:0] w_rise;
  logic [7:0] w_ack_vec;
  logic [7:0] w_ovf_set;
  logic [7:0] w_pending_next;
  logic [7:0] w_overflow_next;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Rising edges are only meaningful on edge-sensitive lines; level lines are
  // forced to zero here so they can never raise overflow.
  assign w_rise = w_sync & ~r_prev & ~LEVEL_MASK;

  // One-hot decode of the acknowledge strobe.
  assign w_ack_vec = ack ? (8'h01 << ack_idx) : 8'h00;

  // A new edge on a line that is pending and not being acknowledged this
  // cycle means the earlier request would be merged, i.e. lost.
  assign w_ovf_set = w_rise & r_pending & ~w_ack_vec;

  // Overflow is sticky until a global clear; level lines never set it.
  assign w_overflow_next = clr_all ? 8'h00 : (r_overflow | w_ovf_set);

  // Per-line pending next state. clr_all has priority over everything except
  // reset; on edge lines a rise beats a same-cycle ack so no edge is dropped.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      if (LEVEL_MASK[gi]) begin : g_level
        assign w_pending_next[gi] = clr_all ? 1'b0 : w_sync[gi];
      end else begin : g_edge
        assign w_pending_next[gi] = clr_all ? 1'b0 :
                                    (w_rise[gi] | (r_pending[gi] & ~w_ack_vec[gi]));
      end
    end
  endgenerate

  // Synchroniser shift and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 8'h00;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
      r_prev <= w_sync;
    end
  end

  // Pending and overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= 8'h00;
      r_overflow <= 8'h00;
    end else begin
      r_pending  <= w_pending_next;
      r_overflow <= w_overflow_next;
    end
  end

  // Outputs depend only on registers and mask; irq_in never reaches them
  // combinationally.
  assign ip          = r_pending & mask;
  assign any_pending = |ip;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Testbench for irq_pending_latch. Three instances share one stimulus stream:
// default (all edge lines), line 0 level-sensitive, and a mixed map with a
// three-stage synchroniser. A behavioural model computes the expected pending
// and overflow vectors from the input history.
module tb_irq_pending_latch;

  localparam int          ND  = 3;
  localparam logic [23:0] LMV = {8'hA5, 8'h01, 8'h00};
  localparam logic [11:0] SSV = {4'd3, 4'd2, 4'd2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = 8'h00;
  logic [7:0] mask = 8'h00;
  logic       ack = 1'b0;
  logic [2:0] ack_idx = 3'd0;
  logic       clr_all = 1'b0;

  logic [7:0] ip_w  [ND];
  logic       any_w [ND];
  logic [7:0] ovf_w [ND];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
      irq_pending_latch #(
        .SYNC_STAGES(int'(SSV[gi*4 +: 4])),
        .LEVEL_MASK (LMV[gi*8 +: 8])
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask       (mask),
        .ack        (ack),
        .ack_idx    (ack_idx),
        .clr_all    (clr_all),
        .ip         (ip_w[gi]),
        .any_pending(any_w[gi]),
        .overflow   (ovf_w[gi])
      );
    end
  endgenerate

  // ---------------- behavioural model ----------------
  // The synchronised value seen before edge n is the irq_in sample taken
  // S edges earlier, provided no reset happened in between; otherwise zero.
  logic [7:0]      hist [16];
  int              cyc = 0;
  int              run_cnt = 0;
  logic [ND*8-1:0] m_pend = '0;
  logic [ND*8-1:0] m_ovf  = '0;

  function automatic logic [2*ND*8-1:0] model_next();
    logic [ND*8-1:0] np, no;
    int         s;
    logic [7:0] lm, sb, pb;
    logic       rise, hit, pend;
    np = '0;
    no = '0;
    for (int d = 0; d < ND; d++) begin
      s  = int'(SSV[d*4 +: 4]);
      lm = LMV[d*8 +: 8];
      sb = (run_cnt >= s)     ? hist[(cyc + 32 - s) % 16] : 8'h00;
      pb = (run_cnt >= s + 1) ? hist[(cyc + 31 - s) % 16] : 8'h00;
      for (int i = 0; i < 8; i++) begin
        pend = m_pend[d*8 + i];
        hit  = ack && (int'(ack_idx) == i);
        if (rst || clr_all) begin
          np[d*8 + i] = 1'b0;
          no[d*8 + i] = 1'b0;
        end else if (lm[i]) begin
          np[d*8 + i] = sb[i];
          no[d*8 + i] = 1'b0;
        end else begin
          rise = sb[i] && !pb[i];
          if (rise)     np[d*8 + i] = 1'b1;
          else if (hit) np[d*8 + i] = 1'b0;
          else          np[d*8 + i] = pend;
          no[d*8 + i] = m_ovf[d*8 + i] | (rise & pend & !hit);
        end
      end
    end
    return {no, np};
  endfunction

  // Advance the model on every active edge using the inputs held across it.
  always @(posedge clk) begin
    {m_ovf, m_pend} <= model_next();
    hist[cyc % 16]  <= irq_in;
    cyc             <= cyc + 1;
    run_cnt         <= rst ? 0 : ((run_cnt < 64) ? run_cnt + 1 : run_cnt);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int d, input logic [7:0] act,
                     input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t: got %02h expected %02h", nm, d, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] enc_y(input logic [7:0] v);
    logic [7:0] y = 8'd0;
    for (int i = 0; i < 8; i++) if (v[i]) y = 8'(i);
    return y;
  endfunction

  // Cycle-by-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        chk("ip",          d, ip_w[d],            m_pend[d*8 +: 8] & mask);
        chk("any_pending", d, {7'd0, any_w[d]},   {7'd0, |(m_pend[d*8 +: 8] & mask)});
        chk("overflow",    d, ovf_w[d],           m_ovf[d*8 +: 8]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_in = v;
    tick();
    tick();
    irq_in = 8'h00;
    tick();
  endtask

  initial begin
    // Reset with everything high
    rst = 1'b1; irq_in = 8'hFF; mask = 8'hFF;
    tick();
    chk_en = 1'b1;
    chk("rst_ip", 0, ip_w[0], 8'h00);
    chk("rst_ovf", 0, ovf_w[0], 8'h00);
    tick();
    chk("rst_ip2", 1, ip_w[1], 8'h00);
    chk("rst_any", 0, {7'd0, any_w[0]}, 8'h00);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("rel_ip", 0, ip_w[0], 8'hFF);
    chk("rel_ip_lvl", 1, ip_w[1], 8'hFF);
    irq_in = 8'h00; clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    repeat (4) tick();

    // Edge capture and ack
    pulse(8'h20);
    chk("edge_ip", 0, ip_w[0], 8'h20);
    tick(); tick();
    chk("edge_hold", 0, ip_w[0], 8'h20);
    ack = 1'b1; ack_idx = 3'd5;
    tick();
    ack = 1'b0;
    chk("ack_ip", 0, ip_w[0], 8'h00);
    chk("ack_any", 0, {7'd0, any_w[0]}, 8'h00);

    // Multiple lines through the encoder
    pulse(8'h92);
    chk("multi_ip", 0, ip_w[0], 8'h92);
    chk("enc_y7", 0, enc_y(ip_w[0]), 8'd7);
    ack = 1'b1; ack_idx = 3'd7;
    tick();
    chk("multi_ip2", 0, ip_w[0], 8'h12);
    chk("enc_y4", 0, enc_y(ip_w[0]), 8'd4);
    ack_idx = 3'd4;
    tick();
    chk("enc_y1", 0, enc_y(ip_w[0]), 8'd1);
    ack_idx = 3'd1;
    tick();
    ack = 1'b0;

    // Overflow and set-beats-clear
    pulse(8'h04);
    tick();
    pulse(8'h04);
    tick();
    chk("ovf_set", 0, ovf_w[0], 8'h04);
    pulse(8'h08);
    tick();
    irq_in = 8'h08;
    tick();
    tick();
    irq_in = 8'h00; ack = 1'b1; ack_idx = 3'd3;
    tick();
    ack = 1'b0;
    chk("setwin_ip", 0, ip_w[0], 8'h0C);
    chk("setwin_ovf", 0, ovf_w[0], 8'h04);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    chk("clr_ip", 0, ip_w[0], 8'h00);
    chk("clr_ovf", 0, ovf_w[0], 8'h00);
    tick(); tick();

    // Reset mid-operation together with ack
    pulse(8'h30);
    tick();
    pulse(8'h10);
    tick();
    chk("pre_rst_ip", 0, ip_w[0], 8'h30);
    chk("pre_rst_ovf", 0, ovf_w[0], 8'h10);
    rst = 1'b1; ack = 1'b1; ack_idx = 3'd4;
    tick();
    rst = 1'b0; ack = 1'b0;
    chk("mid_rst_ip", 0, ip_w[0], 8'h00);
    chk("mid_rst_ovf", 0, ovf_w[0], 8'h00);
    chk("mid_rst_any", 0, {7'd0, any_w[0]}, 8'h00);
    tick(); tick();

    // Mask and level mode (instance 1 has line 0 level-sensitive)
    mask = 8'hFE; irq_in = 8'h01;
    tick(); tick(); tick();
    chk("lvl_masked", 1, ip_w[1], 8'h00);
    mask = 8'hFF;
    #1;
    chk("lvl_unmask", 1, ip_w[1], 8'h01);
    ack = 1'b1; ack_idx = 3'd0;
    tick();
    ack = 1'b0;
    chk("lvl_ack", 1, ip_w[1], 8'h01);
    chk("edge_ack0", 0, ip_w[0], 8'h00);
    irq_in = 8'h00;
    tick(); tick();
    chk("lvl_hold", 1, ip_w[1], 8'h01);
    tick();
    chk("lvl_drop", 1, ip_w[1], 8'h00);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      irq_in  = irq_in ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      ack     = ($urandom_range(0, 2) == 0);
      ack_idx = ($urandom_range(0, 1) == 0) ? enc_y(ip_w[0]) : 3'($urandom);
      clr_all = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; ack = 1'b0; clr_all = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
